// File: rtl/gost_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gost_pkg
// Description : Shared definitions for the GOST 28147-89 key path: key
//               geometry, the loader state encoding and the subkey index type.
//               Imported by the key loader and the key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
package gost_pkg;

    localparam int GOST_WORD_W      = 32;
    localparam int GOST_NUM_SUBKEYS = 8;
    localparam int GOST_KEY_W       = GOST_WORD_W * GOST_NUM_SUBKEYS;

    // Loader state: filling the key register, or holding a complete key
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index of one subkey K1..K8 (0..7)
    typedef logic [2:0] subkey_idx_t;

endpackage : gost_pkg
`default_nettype wire

// File: rtl/gost_key_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : gost_key_loader_if
// Description : Word stream (host -> loader) and key handshake
//               (loader -> key schedule) of the GOST key loader.
//               master : host / consumer side, slave : the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface gost_key_loader_if
    import gost_pkg::*;
#(
    parameter int WORD_W = GOST_WORD_W,
    parameter int KEY_W  = GOST_KEY_W
);

    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;
    logic [KEY_W-1:0]  key_out;
    logic              key_valid;
    logic              key_ack;
    logic              frame_err;

    modport master (
        output word_in, word_valid, word_last, key_ack,
        input  word_ready, key_out, key_valid, frame_err
    );

    modport slave (
        input  word_in, word_valid, word_last, key_ack,
        output word_ready, key_out, key_valid, frame_err
    );

endinterface : gost_key_loader_if
`default_nettype wire

// File: rtl/gost_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : gost_key_loader
// Description : Assembles a 256-bit GOST key from eight 32-bit words received
//               over a valid/ready stream (K1 first, K1 lands in the MSBs) and
//               offers it to the key schedule with a valid/ack handshake.
//               Framing errors (early or missing word_last) pulse frame_err.
//               Optional macro GOST_KEY_ZEROIZE_EN: clear key_out on ack,
//               clr and framing error so key material never lingers.
// Revision    : 1.0 - initial release
// ============================================================================
module gost_key_loader
    import gost_pkg::*;
#(
    parameter int WORD_W    = GOST_WORD_W,
    parameter int NUM_WORDS = GOST_NUM_SUBKEYS
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clr,
    gost_key_loader_if.slave  bus
);

    localparam int KEY_W = WORD_W * NUM_WORDS;

    // Index of the final word; the counter is subkey-sized (up to 8 words)
    localparam subkey_idx_t c_last_idx = subkey_idx_t'(NUM_WORDS - 1);

`ifdef GOST_KEY_ZEROIZE_EN
    localparam bit c_zeroize = 1'b1;
`else
    localparam bit c_zeroize = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    subkey_idx_t       r_count;
    subkey_idx_t       w_count_nxt;
    logic [KEY_W-1:0]  r_key;
    logic              r_live;
    logic              r_frame_err;

    logic              w_accept;
    logic              w_write;
    logic              w_err;
    logic              w_clear_key;

    assign w_accept       = bus.word_valid & bus.word_ready;

    // word_ready stays low until the first edge after reset release
    assign bus.word_ready = r_live & (r_state == ST_FILL);
    assign bus.key_valid  = (r_state == ST_HOLD);
    assign bus.key_out    = r_key;
    assign bus.frame_err  = r_frame_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, word count and datapath control; clr overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_write     = 1'b0;
        w_err       = 1'b0;
        w_clear_key = 1'b0;

        if (clr) begin
            w_state_nxt = ST_FILL;
            w_count_nxt = '0;
            w_clear_key = 1'b1;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        w_write = 1'b1;
                        if (r_count == c_last_idx) begin
                            // Final word must carry word_last to complete the key
                            w_count_nxt = '0;
                            if (bus.word_last) begin
                                w_state_nxt = ST_HOLD;
                            end else begin
                                w_err       = 1'b1;
                                w_clear_key = 1'b1;
                            end
                        end else if (bus.word_last) begin
                            // Early word_last: discard the partial key
                            w_count_nxt = '0;
                            w_err       = 1'b1;
                            w_clear_key = 1'b1;
                        end else begin
                            w_count_nxt = r_count + 3'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.key_ack) begin
                        w_state_nxt = ST_FILL;
                        w_count_nxt = '0;
                        w_clear_key = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_FILL;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // Word counter, ready enable and framing-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_live      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_live      <= 1'b1;
            r_frame_err <= w_err;
        end
    end

    // Key register: indexed word write, optional clear when the key is retired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (c_zeroize && w_clear_key) begin
            r_key <= '0;
        end else if (w_write) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (r_count == subkey_idx_t'(i)) begin
                    r_key[KEY_W-1-i*WORD_W -: WORD_W] <= bus.word_in;
                end
            end
        end
    end

endmodule : gost_key_loader
`default_nettype wire

// File: tb/tb_gost_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gost_key_loader
// Description : Directed self-checking bench for gost_key_loader.
//               Honours GOST_KEY_ZEROIZE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gost_key_loader;

    localparam logic [255:0] c_key_1 =
        256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    localparam logic [255:0] c_key_b =
        256'hCAFE0001_CAFE0002_CAFE0003_CAFE0004_CAFE0005_CAFE0006_CAFE0007_CAFE0008;
    localparam logic [255:0] c_key_a =
        256'h000000A0_000000A1_000000A2_000000A3_000000A4_000000A5_000000A6_000000A7;
    localparam logic [255:0] c_key_c =
        256'h5A5A5A50_5A5A5A51_5A5A5A52_5A5A5A53_5A5A5A54_5A5A5A55_5A5A5A56_5A5A5A57;

`ifdef GOST_KEY_ZEROIZE_EN
    localparam logic [255:0] c_key_after_ack = 256'h0;
`else
    localparam logic [255:0] c_key_after_ack = c_key_1;
`endif

    logic clk;
    logic rst_n;
    logic clr;

    int n_checks;
    int n_pass;

    gost_key_loader_if bus ();

    gost_key_loader u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word for a single clock edge, then withdraw it
    task automatic send_word(input logic [31:0] w, input logic last, input logic c);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        bus.word_last  = last;
        clr            = c;
        @(posedge clk);
        #1;
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
        clr            = 1'b0;
    endtask

    task automatic ack_key();
        bus.key_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.key_ack = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        clr            = 1'b0;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
        bus.key_ack    = 1'b0;

        // Reset state
        #2;
        chk("rst_key_out",    bus.key_out, 256'h0);
        chk("rst_key_valid",  256'(bus.key_valid), 256'h0);
        chk("rst_word_ready", 256'(bus.word_ready), 256'h0);
        chk("rst_frame_err",  256'(bus.frame_err), 256'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 256'(bus.word_ready), 256'h1);

        // Basic load: 0x11111111..0x88888888
        for (int i = 0; i < 7; i++) send_word(32'h11111111 * (i + 1), 1'b0, 1'b0);
        chk("valid_before_last", 256'(bus.key_valid), 256'h0);
        send_word(32'h88888888, 1'b1, 1'b0);
        chk("load1_valid", 256'(bus.key_valid), 256'h1);
        chk("load1_key",   bus.key_out, c_key_1);
        chk("load1_ready", 256'(bus.word_ready), 256'h0);

        // Hold: stray words ignored, then ack
        bus.word_in    = 32'hDEADBEEF;
        bus.word_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.word_valid = 1'b0;
        chk("hold_key",   bus.key_out, c_key_1);
        chk("hold_valid", 256'(bus.key_valid), 256'h1);
        ack_key();
        chk("ack_valid", 256'(bus.key_valid), 256'h0);
        chk("ack_ready", 256'(bus.word_ready), 256'h1);
        chk("ack_key",   bus.key_out, c_key_after_ack);

        // Early word_last on the 3rd word
        send_word(32'h01010101, 1'b0, 1'b0);
        send_word(32'h02020202, 1'b0, 1'b0);
        send_word(32'h03030303, 1'b1, 1'b0);
        chk("early_last_err",   256'(bus.frame_err), 256'h1);
        chk("early_last_valid", 256'(bus.key_valid), 256'h0);
        @(posedge clk);
        #1;
        chk("err_pulse_end", 256'(bus.frame_err), 256'h0);

        // Missing word_last on the 8th word
        for (int i = 0; i < 8; i++) send_word(32'h0F0F0F00 + 32'(i), 1'b0, 1'b0);
        chk("late_last_err",   256'(bus.frame_err), 256'h1);
        chk("late_last_valid", 256'(bus.key_valid), 256'h0);

        // Clean load after framing errors
        for (int i = 0; i < 8; i++) send_word(32'hCAFE0001 + 32'(i), i == 7, 1'b0);
        chk("loadb_valid", 256'(bus.key_valid), 256'h1);
        chk("loadb_key",   bus.key_out, c_key_b);
        ack_key();

        // clr on the 5th accept drops the word and the partial key
        for (int i = 0; i < 4; i++) send_word(32'h77770000 + 32'(i), 1'b0, 1'b0);
        send_word(32'h77770004, 1'b0, 1'b1);
        chk("clr_valid", 256'(bus.key_valid), 256'h0);
        chk("clr_err",   256'(bus.frame_err), 256'h0);
`ifdef GOST_KEY_ZEROIZE_EN
        chk("clr_zero", bus.key_out, 256'h0);
`endif
        for (int i = 0; i < 8; i++) send_word(32'h000000A0 + 32'(i), i == 7, 1'b0);
        chk("loada_valid", 256'(bus.key_valid), 256'h1);
        chk("loada_key",   bus.key_out, c_key_a);
        ack_key();

        // Asynchronous reset after 4 words
        for (int i = 0; i < 4; i++) send_word(32'h33330000 + 32'(i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_key",   bus.key_out, 256'h0);
        chk("async_rst_valid", 256'(bus.key_valid), 256'h0);
        chk("async_rst_ready", 256'(bus.word_ready), 256'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reload, with a key_ack in FILL that must have no effect
        send_word(32'h5A5A5A50, 1'b0, 1'b0);
        send_word(32'h5A5A5A51, 1'b0, 1'b0);
        ack_key();
        for (int i = 2; i < 8; i++) send_word(32'h5A5A5A50 + 32'(i), i == 7, 1'b0);
        chk("loadc_valid", 256'(bus.key_valid), 256'h1);
        chk("loadc_key",   bus.key_out, c_key_c);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gost_key_loader
`default_nettype wire

// File: doc/gost_key_loader.md
Name: gost_key_loader

Overview:
- Writer end of the 256-bit cipher key interface. Accepts the key as eight 32-bit words over a valid/ready stream and assembles them into a 256-bit key register.
- Presents the assembled key, with a valid/ack handshake, to the key-schedule block that splits it into subkeys K1..K8.
- Sits between the host/config bus and the key schedule in the GOST 28147-89 datapath.

Parameters:
- WORD_W, 32, width of one key word (one subkey).
- NUM_WORDS, 8, words per key; KEY_W = WORD_W*NUM_WORDS is a localparam (256).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush: discards a partial or held key.
- word_in  input  WORD_W  key word; the first word is K1.
- word_valid  input  1  word_in is valid.
- word_last  input  1  marks the final word; qualified by word_valid.
- word_ready  output  1  loader can accept a word.
- key_out  output  KEY_W  assembled key; K1 in [255:224], K8 in [31:0].
- key_valid  output  1  key_out holds a complete key.
- key_ack  input  1  consumer has taken the key.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, word count=0.
  - key_out=0, key_valid=0, word_ready=0 while rst_n is low; word_ready=1 from the first cycle after release. frame_err=0.
- A word is accepted on a rising edge with word_valid & word_ready.
- FILL state:
  - word_ready=1, key_valid=0.
  - Accepted word n (0..7) is written to key_out[KEY_W-1-n*WORD_W -: WORD_W]; count increments.
  - Count is 3 bits and wraps only via the 8th-word transition.
- 8th word accepted with word_last=1:
  - Go to HOLD on the same edge.
  - key_valid=1 and word_ready=0 in the next cycle (latency 1 edge from the last accept).
- Framing error, flagged on the accept edge:
  - Cases: word_last=1 on words 1..7, or word_last=0 on word 8.
  - frame_err pulses for exactly 1 cycle. Count goes to 0, state stays FILL.
  - The offending word is not kept as a valid key. key_out contents are don't-care until the next complete load.
- HOLD state:
  - word_ready=0; word_valid is ignored and does not stall anything.
  - key_out is stable while key_valid=1.
  - key_ack=1 → next edge: key_valid=0, state=FILL, count=0, word_ready=1.
  - key_ack while key_valid=0 has no effect.
- clr=1 (any state): next edge gives count=0, state=FILL, key_valid=0. clr has priority over a simultaneous accept or key_ack, and the accepted word is dropped.
- Reset mid-load: the partial key is lost immediately (async). There is no resume.
- The loader never issues back-to-back keys without an intervening key_ack.

Optional Feature:
- Macro: GOST_KEY_ZEROIZE_EN.
- Defined:
  - key_out is cleared to 0 on the edge that consumes key_ack, on clr, and on a framing error, so key material never lingers.
  - key_out reads 0 whenever state=FILL and count=0.
- Undefined:
  - key_out keeps its last contents after ack, clr or error; only key_valid qualifies it.
  - Saves 256 clear-mux cells.

Decomposition:
- Shared package gost_pkg holds:
  - GOST_WORD_W=32, GOST_NUM_SUBKEYS=8, GOST_KEY_W=256;
  - the state enum {ST_FILL, ST_HOLD};
  - a subkey-index type (3 bits).
- The key schedule block imports the same package.
- No sub-module: counter, FSM and the shift/indexed write fit naturally in one block.

Test Plan:
- Load words 0x11111111..0x88888888 (last on the 8th), key_ack held 0 → key_valid=1 one edge after the 8th accept. key_out=0x11111111_22222222_..._88888888. word_ready=0 while held.
- Hold with key_valid=1, drive word_valid=1 with word_in=0xDEADBEEF for 5 cycles, then key_ack=1 → key_out unchanged. key_valid=0 and word_ready=1 the cycle after ack.
- Assert word_last on the 3rd word → frame_err=1 for 1 cycle, key_valid stays 0. A following full 8-word load yields the correct key.
- Assert clr on the same edge as the 5th word accept → no key_valid. The next 8 words (0xA0..0xA7) load cleanly into key_out.
- Pull rst_n low for 1 cycle asynchronously mid-load (after 4 words) → key_out=0 and key_valid=0 immediately. A full reload then succeeds.
- GOST_KEY_ZEROIZE_EN defined, complete a load and ack → key_out=0 on the ack edge. Undefined → key_out retains 0x11111111...88888888.
